ame_pri_scan: RTL and testbench

// Sequencer for the AME 8-bit priority slices. It takes one wide candidate mask and hands out the index of

---
 rtl/ame_pri_pkg.sv | 23 ++
 rtl/ame_pri_slice8.sv | 24 ++
 rtl/ame_pri_scan.sv | 133 +++++++++++++
 tb/tb_ame_pri_scan.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ame_pri_pkg.sv
// Shared types and helpers for the AME priority scan sequencer.
// Holds the FSM state type, the slice width and a slice-wide bit reversal.
package ame_pri_pkg;

  typedef enum logic {
    IDLE,
    SCAN
  } ame_pri_state_t;

  localparam int SLICE_W = 8;

  // Full-width reversal is built from this by also reversing slice order.
  function automatic logic [SLICE_W-1:0] bit_rev(
    input logic [SLICE_W-1:0] v
  );
    logic [SLICE_W-1:0] r;
    for (int i = 0; i < SLICE_W; i++) begin
      r[i] = v[SLICE_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ame_pri_slice8.sv
// 8-bit priority slice: one-hot of the lowest set bit, gated by carry.
// Ports: data_i, carry_i in; onehot_o, carry_o (no bit set) out.
module ame_pri_slice8
  import ame_pri_pkg::*;
(
  input  logic [SLICE_W-1:0] data_i,
  input  logic               carry_i,
  output logic [SLICE_W-1:0] onehot_o,
  output logic               carry_o
);

  logic seen;

  always_comb begin
    onehot_o = '0;
    seen     = 1'b0;
    for (int b = 0; b < SLICE_W; b++) begin
      onehot_o[b] = carry_i & data_i[b] & ~seen;
      seen        = seen | data_i[b];
    end
    carry_o = carry_i & ~seen;
  end

endmodule

// File: rtl/ame_pri_scan.sv
// Issues the index of every set bit of a mask, one per cycle, LSB/MSB first.
// Ports: load_* job request, abort_i, out_* index stream, busy/done/cnt status.
module ame_pri_scan
  import ame_pri_pkg::*;
#(
  parameter int N_BITS = 64,
  parameter int IDX_W  = $clog2(N_BITS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [N_BITS-1:0] load_mask_i,
  input  logic              load_msb_i,
  input  logic              abort_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [IDX_W:0]    cnt_o
);

  localparam int NS = N_BITS / SLICE_W;
  localparam logic [N_BITS-1:0] ONE = N_BITS'(1);
  localparam logic [IDX_W:0]    CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(N_BITS - 1);

  ame_pri_state_t state_q, state_n;
  logic [N_BITS-1:0] rem_q, rem_n;
  logic              dir_q, dir_n;
  logic [IDX_W:0]    cnt_n;
  logic              done_n;

  logic [N_BITS-1:0] scan_in;
  logic [N_BITS-1:0] onehot;
  logic [NS:0]       carry;
  logic [IDX_W-1:0]  idx_raw;
  logic              xfer;

  // MSB-first reuses the LSB-first network on the reversed mask.
  always_comb begin
    scan_in = rem_q;
    if (dir_q) begin
      for (int s = 0; s < NS; s++) begin
        scan_in[s*SLICE_W +: SLICE_W] =
          bit_rev(rem_q[(NS-1-s)*SLICE_W +: SLICE_W]);
      end
    end
  end

  assign carry[0] = 1'b1;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    ame_pri_slice8 u_slice (
      .data_i   (scan_in[s*SLICE_W +: SLICE_W]),
      .carry_i  (carry[s]),
      .onehot_o (onehot[s*SLICE_W +: SLICE_W]),
      .carry_o  (carry[s+1])
    );
  end

  always_comb begin
    idx_raw = '0;
    for (int i = 0; i < N_BITS; i++) begin
      if (onehot[i]) idx_raw = idx_raw | IDX_W'(i);
    end
  end

  assign out_idx_o  = dir_q ? (IDX_TOP - idx_raw) : idx_raw;
  assign out_last_o = ((rem_q & (rem_q - ONE)) == '0);

  // Final carry high means nothing left; never present valid then.
  assign out_valid_o  = (state_q == SCAN) & ~abort_i & ~carry[NS];
  assign load_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign xfer         = out_valid_o & out_ready_i;

  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    dir_n   = dir_q;
    cnt_n   = cnt_o;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid_i) begin
          rem_n = load_mask_i;
          dir_n = load_msb_i;
          cnt_n = '0;
          if (load_mask_i != '0) state_n = SCAN;
          else done_n = 1'b1;
        end
      end
      SCAN: begin
        unique case (1'b1)
          abort_i: begin
            state_n = IDLE;
            rem_n   = '0;
          end
          xfer: begin
            rem_n = rem_q & ~(ONE << out_idx_o);
            cnt_n = cnt_o + CNT_ONE;
            if (out_last_o) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      cnt_o   <= '0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      dir_q   <= dir_n;
      cnt_o   <= cnt_n;
      done_o  <= done_n;
    end
  end

endmodule

// File: tb/tb_ame_pri_scan.sv
// Directed bench for ame_pri_scan (N_BITS=64).
// Walks empty, LSB, MSB, backpressure, abort and reset-mid-job jobs.
module tb_ame_pri_scan;

  localparam int N_BITS = 64;
  localparam int IDX_W  = 6;

  logic              clk_i;
  logic              rst_n_i;
  logic              load_valid_i;
  logic              load_ready_o;
  logic [N_BITS-1:0] load_mask_i;
  logic              load_msb_i;
  logic              abort_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [IDX_W-1:0]  out_idx_o;
  logic              out_last_o;
  logic              busy_o;
  logic              done_o;
  logic [IDX_W:0]    cnt_o;

  int total = 0;
  int bad   = 0;

  ame_pri_scan #(.N_BITS(N_BITS)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_mask_i  (load_mask_i),
    .load_msb_i   (load_msb_i),
    .abort_i      (abort_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_idx_o    (out_idx_o),
    .out_last_o   (out_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cnt_o        (cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx,
                         input logic last);
    chk({tag, ".valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, ".idx"}, 64'(out_idx_o), 64'(idx));
    chk({tag, ".last"}, 64'(out_last_o), 64'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, ".busy"}, 64'(busy_o), 64'd0);
    chk({tag, ".lrdy"}, 64'(load_ready_o), 64'd1);
  endtask

  initial begin
    rst_n_i      = 1'b0;
    load_valid_i = 1'b0;
    load_mask_i  = '0;
    load_msb_i   = 1'b0;
    abort_i      = 1'b0;
    out_ready_i  = 1'b1;
    tick();
    tick();
    rst_n_i = 1'b1;
    chk_idle("rst");
    chk("rst.cnt", 64'(cnt_o), 64'd0);
    chk("rst.done", 64'(done_o), 64'd0);

    // empty mask
    load_valid_i = 1'b1;
    load_mask_i  = '0;
    tick();
    load_valid_i = 1'b0;
    chk("empty.done", 64'(done_o), 64'd1);
    chk("empty.cnt", 64'(cnt_o), 64'd0);
    chk_idle("empty");
    tick();
    chk("empty.done2", 64'(done_o), 64'd0);
    chk("empty.valid2", 64'(out_valid_o), 64'd0);

    // LSB-first
    load_valid_i = 1'b1;
    load_mask_i  = 64'h8000_0000_0000_0011;
    load_msb_i   = 1'b0;
    tick();
    load_valid_i = 1'b0;
    chk("lsb.busy", 64'(busy_o), 64'd1);
    chk("lsb.lrdy", 64'(load_ready_o), 64'd0);
    chk_out("lsb0", 0, 1'b0);
    tick();
    chk_out("lsb1", 4, 1'b0);
    tick();
    chk_out("lsb2", 63, 1'b1);
    tick();
    chk("lsb.done", 64'(done_o), 64'd1);
    chk("lsb.cnt", 64'(cnt_o), 64'd3);
    chk_idle("lsb.end");

    // MSB-first, loaded in the done cycle
    load_valid_i = 1'b1;
    load_msb_i   = 1'b1;
    tick();
    load_valid_i = 1'b0;
    chk("msb.cnt0", 64'(cnt_o), 64'd0);
    chk_out("msb0", 63, 1'b0);
    tick();
    chk_out("msb1", 4, 1'b0);
    tick();
    chk_out("msb2", 0, 1'b1);
    tick();
    chk("msb.done", 64'(done_o), 64'd1);
    chk("msb.cnt", 64'(cnt_o), 64'd3);
    chk_idle("msb.end");
    tick();
    chk("msb.done2", 64'(done_o), 64'd0);

    // backpressure: bits 0,2,3,6,7
    load_valid_i = 1'b1;
    load_mask_i  = 64'h0000_0000_0000_00cd;
    load_msb_i   = 1'b0;
    out_ready_i  = 1'b0;
    tick();
    load_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_out("bp.stall", 0, 1'b0);
      chk("bp.stall.cnt", 64'(cnt_o), 64'd0);
      tick();
    end
    out_ready_i = 1'b1;
    chk_out("bp0", 0, 1'b0);
    tick();
    chk_out("bp1", 2, 1'b0);
    tick();
    chk_out("bp2", 3, 1'b0);
    tick();
    chk_out("bp3", 6, 1'b0);
    tick();
    chk_out("bp4", 7, 1'b1);
    tick();
    chk("bp.done", 64'(done_o), 64'd1);
    chk("bp.cnt", 64'(cnt_o), 64'd5);

    // abort after two transfers
    load_valid_i = 1'b1;
    load_mask_i  = '1;
    tick();
    load_valid_i = 1'b0;
    chk_out("ab0", 0, 1'b0);
    tick();
    chk_out("ab1", 1, 1'b0);
    tick();
    chk_out("ab2", 2, 1'b0);
    abort_i = 1'b1;
    #1;
    chk("ab.gate", 64'(out_valid_o), 64'd0);
    tick();
    abort_i = 1'b0;
    chk_idle("ab.idle");
    chk("ab.done", 64'(done_o), 64'd0);
    chk("ab.cnt", 64'(cnt_o), 64'd2);
    tick();
    chk("ab.done2", 64'(done_o), 64'd0);
    chk("ab.cnt2", 64'(cnt_o), 64'd2);

    // follow-up job after abort
    load_valid_i = 1'b1;
    load_mask_i  = 64'h1;
    tick();
    load_valid_i = 1'b0;
    chk_out("fu0", 0, 1'b1);
    tick();
    chk("fu.done", 64'(done_o), 64'd1);
    chk("fu.cnt", 64'(cnt_o), 64'd1);

    // reset mid-job
    load_valid_i = 1'b1;
    load_mask_i  = '1;
    tick();
    load_valid_i = 1'b0;
    tick();
    chk_out("rj1", 1, 1'b0);
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    chk_idle("rj");
    chk("rj.cnt", 64'(cnt_o), 64'd0);
    chk("rj.done", 64'(done_o), 64'd0);
    tick();
    chk("rj.valid2", 64'(out_valid_o), 64'd0);
    chk("rj.done2", 64'(done_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
